// File: rtl/mips_test_sequencer.sv
// mips_test_sequencer: steps through a loaded program of instruction words,
// drives each one to a combinational MIPS core, waits for the core to settle
// and scores the returned result against the expected value stored with it.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | out of reset, waiting for start; program memory writable
// S_ISSUE  | drive instr_mem[idx] onto instruction_out, arm settle timer
// S_SETTLE | down-count the settle timer while the core output settles
// S_CHECK  | compare result_in with expect_mem[idx], advance or finish
// S_DONE   | run finished, counters held; program memory writable
module mips_test_sequencer #(
  parameter int DEPTH  = 16,
  parameter int SETTLE = 1,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_instr,
  input  logic [31:0]   load_expect,
  input  logic [CW-1:0] prog_len,
  input  logic          start,
  output logic [31:0]   instruction_out,
  input  logic [31:0]   result_in,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] pass_count,
  output logic [CW-1:0] fail_count,
  output logic [AW-1:0] first_fail_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [CW-1:0] len_q, len_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   instr_q, instr_d;
  logic [CW-1:0] pass_q, pass_d;
  logic [CW-1:0] fail_q, fail_d;
  logic [AW-1:0] ffi_q, ffi_d;

  logic [31:0]   instr_mem  [DEPTH];
  logic [31:0]   expect_mem [DEPTH];

  logic          idle_or_done;
  logic          wr_en;

  assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
  assign wr_en        = load_en && idle_or_done && ({1'b0, load_addr} < CW'(DEPTH));

  // Program memory: no reset so a loaded program survives rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      instr_mem[load_addr]  <= load_instr;
      expect_mem[load_addr] <= load_expect;
    end
  end

  // Next-state and datapath updates for the sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    ffi_d   = ffi_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          idx_d   = '0;
          pass_d  = '0;
          fail_d  = '0;
          ffi_d   = '0;
          // Over-long programs are clipped to the memory size.
          len_d   = (prog_len > CW'(DEPTH)) ? CW'(DEPTH) : prog_len;
          state_d = (prog_len == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        instr_d = instr_mem[idx_q];
        cnt_d   = 4'(SETTLE);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        // Leaving at a count of 1 makes SETTLE last exactly SETTLE cycles.
        if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (result_in == expect_mem[idx_q]) begin
          pass_d = pass_q + CW'(1);
        end else begin
          fail_d = fail_q + CW'(1);
          if (fail_q == '0) begin
            ffi_d = idx_q;
          end
        end
        if ({1'b0, idx_q} == (len_q - CW'(1))) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      instr_q <= 32'h0000_0000;
      pass_q  <= '0;
      fail_q  <= '0;
      ffi_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      ffi_q   <= ffi_d;
    end
  end

  assign instruction_out = instr_q;
  assign busy            = (state_q == S_ISSUE) || (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign done            = (state_q == S_DONE);
  assign pass_count      = pass_q;
  assign fail_count      = fail_q;
  assign first_fail_idx  = ffi_q;

endmodule

// File: tb/tb_mips_test_sequencer.sv
// Bench for mips_test_sequencer: a run-level model predicts every output on
// every cycle, and directed scenarios pin the model with literal values.
module tb_mips_test_sequencer;

  localparam int DEPTH = 16;
  localparam int S     = 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_instr;
  logic [31:0]   load_expect;
  logic [CW-1:0] prog_len;
  logic          start;
  logic [31:0]   instruction_out;
  logic [31:0]   result_in;
  logic          busy;
  logic          done;
  logic [CW-1:0] pass_count;
  logic [CW-1:0] fail_count;
  logic [AW-1:0] first_fail_idx;

  logic          ov_en  = 1'b0;
  logic [31:0]   ov_val = 32'h0;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  mips_test_sequencer #(.DEPTH(DEPTH), .SETTLE(S)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_instr(load_instr), .load_expect(load_expect), .prog_len(prog_len),
    .start(start), .instruction_out(instruction_out), .result_in(result_in),
    .busy(busy), .done(done), .pass_count(pass_count), .fail_count(fail_count),
    .first_fail_idx(first_fail_idx)
  );

  always #5 clk = ~clk;

  // Toy core: halfword swap plus a constant, or a forced value.
  function automatic logic [31:0] good(input logic [31:0] i);
    return {i[15:0], i[31:16]} + 32'h0000_1234;
  endfunction

  assign result_in = ov_en ? ov_val : ({instruction_out[15:0], instruction_out[31:16]} + 32'h0000_1234);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Run-level model: a run is len entries of (S+2) cycles each.
  bit          m_run, m_done;
  int          m_t, m_len, m_pass, m_fail, m_ffi;
  logic [31:0] m_instr;
  logic [31:0] m_imem [DEPTH];
  logic [31:0] m_emem [DEPTH];

  task automatic model_step();
    int p, e;
    logic [31:0] r;
    if (!rst_n) begin
      m_run = 0; m_done = 0; m_instr = 32'h0;
      m_pass = 0; m_fail = 0; m_ffi = 0;
      return;
    end
    if (!m_run) begin
      if (load_en) begin
        m_imem[load_addr] = load_instr;
        m_emem[load_addr] = load_expect;
      end
      if (start) begin
        m_len  = (int'(prog_len) > DEPTH) ? DEPTH : int'(prog_len);
        m_pass = 0; m_fail = 0; m_ffi = 0;
        if (m_len == 0) m_done = 1;
        else begin m_run = 1; m_done = 0; m_t = 0; end
      end
    end else begin
      p = m_t % (S + 2);
      e = m_t / (S + 2);
      if (p == 0) m_instr = m_imem[e];
      else if (p == S + 1) begin
        r = ov_en ? ov_val : good(m_instr);
        if (r == m_emem[e]) m_pass++;
        else begin
          if (m_fail == 0) m_ffi = e;
          m_fail++;
        end
        if (e == m_len - 1) begin m_run = 0; m_done = 1; end
      end
      m_t++;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("busy", 32'(busy), 32'(m_run));
        chk("done", 32'(done), 32'(m_done));
        chk("instruction_out", instruction_out, m_instr);
        chk("pass_count", 32'(pass_count), 32'(m_pass));
        chk("fail_count", 32'(fail_count), 32'(m_fail));
        if (m_fail > 0) chk("first_fail_idx", 32'(first_fail_idx), 32'(m_ffi));
      end
    end
  end

  task automatic load(input int a, input logic [31:0] ins, input logic [31:0] ex);
    @(negedge clk);
    load_en = 1'b1; load_addr = AW'(a); load_instr = ins; load_expect = ex;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic pulse_start(input int len);
    @(negedge clk);
    prog_len = CW'(len); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!done && cyc < 2000);
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  function automatic logic [31:0] prog_instr(input int i);
    return 32'h0100_0000 * i + 32'h0000_8020 + 32'(i);
  endfunction

  localparam logic [15:0] BAD = 16'b1000_0010_0010_1010;  // entries 1,3,5,9,15

  initial begin
    int c;
    logic [15:0] badv;
    rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_instr = '0;
    load_expect = '0; prog_len = '0; start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_instr", instruction_out, 32'h0);
    chk("rst_pass", 32'(pass_count), 32'd0);
    chk("rst_fail", 32'(fail_count), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Single entry, core forced to return 5.
    load(0, 32'h0020_5020, 32'h0000_0005);
    ov_en = 1'b1; ov_val = 32'h0000_0005;
    pulse_start(1);
    @(posedge clk); #1;
    chk("t040_instr", instruction_out, 32'h0020_5020);
    wait_done(c);
    chk("t040_cycles", 32'(c + 1), 32'd3);
    chk("t040_pass", 32'(pass_count), 32'd1);
    chk("t040_fail", 32'(fail_count), 32'd0);
    ov_en = 1'b0;

    // Full program with mismatching expectations at BAD entries.
    badv = BAD;
    for (int i = 0; i < DEPTH; i++)
      load(i, prog_instr(i), good(prog_instr(i)) ^ (badv[i] ? 32'h1 : 32'h0));
    pulse_start(4);
    wait_done(c);
    chk("t041_cycles", 32'(c), 32'd12);
    chk("t041_pass", 32'(pass_count), 32'd2);
    chk("t041_fail", 32'(fail_count), 32'd2);
    chk("t041_ffi", 32'(first_fail_idx), 32'd1);

    // start and load_en during SETTLE of entry 0 are ignored.
    pulse_start(4);
    @(negedge clk);
    start = 1'b1; prog_len = CW'(1); load_en = 1'b1; load_addr = '0;
    load_instr = 32'hDEAD_BEEF; load_expect = good(32'hDEAD_BEEF);
    @(negedge clk);
    start = 1'b0; load_en = 1'b0;
    wait_done(c);
    chk("t043_cycles", 32'(c), 32'd10);
    chk("t043_pass", 32'(pass_count), 32'd2);
    chk("t043_fail", 32'(fail_count), 32'd2);
    chk("t043_ffi", 32'(first_fail_idx), 32'd1);

    // Reset during SETTLE of entry 2, then rerun from retained memory.
    pulse_start(4);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t044_busy", 32'(busy), 32'd0);
    chk("t044_done", 32'(done), 32'd0);
    chk("t044_instr", instruction_out, 32'h0);
    chk("t044_pass", 32'(pass_count), 32'd0);
    chk("t044_fail", 32'(fail_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulse_start(4);
    wait_done(c);
    chk("t044_cycles", 32'(c), 32'd12);
    chk("t044_rpass", 32'(pass_count), 32'd2);
    chk("t044_rfail", 32'(fail_count), 32'd2);
    chk("t044_ffi", 32'(first_fail_idx), 32'd1);

    // All 16 entries twice; second start from DONE clears counters.
    for (int r = 0; r < 2; r++) begin
      pulse_start(16);
      chk("t045_clr_pass", 32'(pass_count), 32'd0);
      chk("t045_clr_fail", 32'(fail_count), 32'd0);
      wait_done(c);
      chk("t045_cycles", 32'(c), 32'd48);
      chk("t045_pass", 32'(pass_count), 32'd11);
      chk("t045_fail", 32'(fail_count), 32'd5);
      chk("t045_ffi", 32'(first_fail_idx), 32'd1);
    end

    // Over-long prog_len is clipped to DEPTH.
    pulse_start(20);
    wait_done(c);
    chk("clip_cycles", 32'(c), 32'd48);
    chk("clip_pass", 32'(pass_count), 32'd11);

    // prog_len=0 goes straight to DONE with counters cleared.
    pulse_start(0);
    wait_done(c);
    chk("t042_cycles", 32'(c), 32'd1);
    chk("t042_pass", 32'(pass_count), 32'd0);
    chk("t042_fail", 32'(fail_count), 32'd0);
    chk("t042_instr", instruction_out, prog_instr(15));

    // Same-cycle load and start: the run sees the new entry.
    @(negedge clk);
    load_en = 1'b1; load_addr = '0; load_instr = 32'hCAFE_0001; load_expect = 32'h0;
    start = 1'b1; prog_len = CW'(1);
    @(negedge clk);
    load_en = 1'b0; start = 1'b0;
    wait_done(c);
    chk("t035_cycles", 32'(c), 32'd3);
    chk("t035_instr", instruction_out, 32'hCAFE_0001);
    chk("t035_fail", 32'(fail_count), 32'd1);
    chk("t035_ffi", 32'(first_fail_idx), 32'd0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
